// File: rtl/snn_timestep_scheduler_if.sv
// Groups the frame-in, datapath-control and count-out signals of the timestep scheduler.
// Latency: none, wires only.
// Backpressure: carries in_valid/in_ready and out_valid/out_ready; the modports only set direction.
interface snn_timestep_scheduler_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
);
    // frame input handshake
    logic              i_in_valid;
    logic              o_in_ready;
    logic [DATA_W-1:0] i_in_data0;
    logic [DATA_W-1:0] i_in_data1;
    logic [DATA_W-1:0] i_in_data2;

    // datapath control and spike feedback
    logic [DATA_W-1:0] o_nrn_data0;
    logic [DATA_W-1:0] o_nrn_data1;
    logic [DATA_W-1:0] o_nrn_data2;
    logic              o_nrn_clr;
    logic              o_nrn_en;
    logic              i_spk0;
    logic              i_spk1;
    logic              i_spk2;

    // spike count output handshake
    logic              o_out_valid;
    logic              i_out_ready;
    logic [CNT_W-1:0]  o_cnt0;
    logic [CNT_W-1:0]  o_cnt1;
    logic [CNT_W-1:0]  o_cnt2;
    logic              o_busy;

    // environment side: upstream frame source, datapath and count consumer
    modport master (
        output i_in_valid, i_in_data0, i_in_data1, i_in_data2,
        output i_spk0, i_spk1, i_spk2, i_out_ready,
        input  o_in_ready, o_nrn_data0, o_nrn_data1, o_nrn_data2,
        input  o_nrn_clr, o_nrn_en, o_out_valid, o_cnt0, o_cnt1, o_cnt2, o_busy
    );

    // scheduler side
    modport slave (
        input  i_in_valid, i_in_data0, i_in_data1, i_in_data2,
        input  i_spk0, i_spk1, i_spk2, i_out_ready,
        output o_in_ready, o_nrn_data0, o_nrn_data1, o_nrn_data2,
        output o_nrn_clr, o_nrn_en, o_out_valid, o_cnt0, o_cnt1, o_cnt2, o_busy
    );
endinterface

// File: rtl/snn_timestep_scheduler.sv
// Runs one input frame through the 3-channel SNN datapath for NUM_TIMESTEPS steps and counts spikes per channel.
// Latency: counts are valid 2 + NUM_TIMESTEPS*(1+SETTLE_CYCLES) cycles after the frame is accepted.
// Backpressure: accepts a frame only in IDLE, with no buffering; counts hold in DONE until out_ready.
module snn_timestep_scheduler #(
    parameter int DATA_W        = 8,
    parameter int NUM_TIMESTEPS = 16,
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    snn_timestep_scheduler_if.slave  bus
);

    localparam int STEP_W = (NUM_TIMESTEPS > 1) ? $clog2(NUM_TIMESTEPS) : 1;
    localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [STEP_W-1:0] LAST_STEP   = STEP_W'(NUM_TIMESTEPS - 1);
    localparam logic [SET_W-1:0]  LAST_SETTLE = SET_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        STEP  = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t             state;
    logic [STEP_W-1:0]  step;
    logic [SET_W-1:0]   settle;

    // A counter that has reached all-ones stays there rather than wrapping to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic spk);
        logic [CNT_W-1:0] res;
        res = cnt;
        if (spk && (cnt != {CNT_W{1'b1}})) begin
            res = cnt + CNT_W'(1);
        end
        return res;
    endfunction

    // Handshake status decoded straight from the state.
    assign bus.o_in_ready = (state == IDLE);
    assign bus.o_busy     = (state != IDLE);

    // Frame sequencer. The clr/en/valid outputs are registered, so each one is
    // set on the edge that enters the state in which it must be high.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state           <= IDLE;
            step            <= '0;
            settle          <= '0;
            bus.o_nrn_data0 <= '0;
            bus.o_nrn_data1 <= '0;
            bus.o_nrn_data2 <= '0;
            bus.o_cnt0      <= '0;
            bus.o_cnt1      <= '0;
            bus.o_cnt2      <= '0;
            bus.o_nrn_clr   <= 1'b0;
            bus.o_nrn_en    <= 1'b0;
            bus.o_out_valid <= 1'b0;
        end else begin
            // clr and en are one-cycle pulses unless a transition below re-arms them
            bus.o_nrn_clr <= 1'b0;
            bus.o_nrn_en  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_in_valid) begin
                        // the frame stays on the datapath inputs until the next accept
                        bus.o_nrn_data0 <= bus.i_in_data0;
                        bus.o_nrn_data1 <= bus.i_in_data1;
                        bus.o_nrn_data2 <= bus.i_in_data2;
                        bus.o_cnt0      <= '0;
                        bus.o_cnt1      <= '0;
                        bus.o_cnt2      <= '0;
                        bus.o_nrn_clr   <= 1'b1;
                        state           <= CLEAR;
                    end
                end
                CLEAR: begin
                    step         <= '0;
                    bus.o_nrn_en <= 1'b1;
                    state        <= STEP;
                end
                STEP: begin
                    settle <= '0;
                    state  <= WAIT;
                end
                WAIT: begin
                    if (settle == LAST_SETTLE) begin
                        // The datapath has settled, so the spike flags now belong to this step.
                        bus.o_cnt0 <= sat_inc(bus.o_cnt0, bus.i_spk0);
                        bus.o_cnt1 <= sat_inc(bus.o_cnt1, bus.i_spk1);
                        bus.o_cnt2 <= sat_inc(bus.o_cnt2, bus.i_spk2);
                        if (step == LAST_STEP) begin
                            bus.o_out_valid <= 1'b1;
                            state           <= DONE;
                        end else begin
                            step         <= step + STEP_W'(1);
                            bus.o_nrn_en <= 1'b1;
                            state        <= STEP;
                        end
                    end else begin
                        settle <= settle + SET_W'(1);
                    end
                end
                DONE: begin
                    if (bus.i_out_ready) begin
                        bus.o_out_valid <= 1'b0;
                        state           <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snn_timestep_scheduler.sv
// Scoreboard bench for snn_timestep_scheduler: two instances (T=4,S=2,W=8 and T=8,S=1,W=2).
// Latency: expected clr/en/valid cycles are computed from the frame accept cycle.
// Backpressure: out_ready is stalled in DONE while a competing frame is offered.
`timescale 1ns/1ps
module tb_snn_timestep_scheduler;

    localparam int T_A = 4;
    localparam int S_A = 2;
    localparam int W_A = 8;
    localparam int T_B = 8;
    localparam int S_B = 1;
    localparam int W_B = 2;

    typedef struct packed {
        logic [7:0] c0, c1, c2, d0, d1, d2;
    } res_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    snn_timestep_scheduler_if #(.DATA_W(8), .CNT_W(W_A)) bus_a();
    snn_timestep_scheduler_if #(.DATA_W(8), .CNT_W(W_B)) bus_b();

    snn_timestep_scheduler #(.DATA_W(8), .NUM_TIMESTEPS(T_A), .SETTLE_CYCLES(S_A), .CNT_W(W_A))
        u_dut_a (.i_clk(clk), .i_rstn(rstn), .bus(bus_a.slave));
    snn_timestep_scheduler #(.DATA_W(8), .NUM_TIMESTEPS(T_B), .SETTLE_CYCLES(S_B), .CNT_W(W_B))
        u_dut_b (.i_clk(clk), .i_rstn(rstn), .bus(bus_b.slave));

    // expected events and results
    int   clr_q[$];
    int   en_q[$];
    int   vld_q[$];
    res_t res_q[$];
    res_t resb_q[$];
    int   last_hs = -100;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event at cycle %0d, none expected", name, cyc);
    endtask

    // datapath stand-in for instance A: per-step spike patterns driven only in the sampling cycle
    logic [15:0] pat0 = '0, pat1 = '0, pat2 = '0;
    int  spk_idx = 0, spk_cur = 0, spk_cnt = 0;
    bit  spk_act = 0;
    always @(negedge clk) begin
        if (bus_a.o_nrn_clr) spk_idx = 0;
        if (bus_a.o_nrn_en) begin
            spk_cur = spk_idx;
            spk_idx++;
            spk_cnt = 0;
            spk_act = 1;
        end else if (spk_act) begin
            spk_cnt++;
        end
        if (spk_act && spk_cnt == S_A) begin
            bus_a.i_spk0 = pat0[spk_cur];
            bus_a.i_spk1 = pat1[spk_cur];
            bus_a.i_spk2 = pat2[spk_cur];
            spk_act = 0;
        end else begin
            bus_a.i_spk0 = 1'($urandom_range(0, 1));
            bus_a.i_spk1 = 1'($urandom_range(0, 1));
            bus_a.i_spk2 = 1'($urandom_range(0, 1));
        end
    end

    // monitor A: pops expected pulses/results as the DUT presents them
    bit   prev_vld_a = 0;
    res_t mon_r;
    always @(negedge clk) begin
        if (bus_a.o_nrn_clr) begin
            if (clr_q.size() == 0) fail_now("clr_unexpected");
            else check("clr_cycle", cyc, clr_q.pop_front());
        end
        if (bus_a.o_nrn_en) begin
            if (en_q.size() == 0) fail_now("en_unexpected");
            else check("en_cycle", cyc, en_q.pop_front());
        end
        if (bus_a.o_out_valid && !prev_vld_a) begin
            if (vld_q.size() == 0) fail_now("valid_unexpected");
            else check("valid_cycle", cyc, vld_q.pop_front());
        end
        if (bus_a.o_out_valid && bus_a.i_out_ready) begin
            last_hs = cyc;
            if (res_q.size() == 0) fail_now("result_unexpected");
            else begin
                mon_r = res_q.pop_front();
                check("cnt0", bus_a.o_cnt0, mon_r.c0);
                check("cnt1", bus_a.o_cnt1, mon_r.c1);
                check("cnt2", bus_a.o_cnt2, mon_r.c2);
                check("nrn_data0", bus_a.o_nrn_data0, mon_r.d0);
                check("nrn_data1", bus_a.o_nrn_data1, mon_r.d1);
                check("nrn_data2", bus_a.o_nrn_data2, mon_r.d2);
            end
        end
        prev_vld_a = bus_a.o_out_valid;
    end

    // monitor B: saturation results
    res_t mon_b;
    always @(negedge clk) begin
        if (bus_b.o_out_valid && bus_b.i_out_ready) begin
            if (resb_q.size() == 0) fail_now("b_result_unexpected");
            else begin
                mon_b = resb_q.pop_front();
                check("b_cnt0", bus_b.o_cnt0, mon_b.c0);
                check("b_cnt1", bus_b.o_cnt1, mon_b.c1);
                check("b_cnt2", bus_b.o_cnt2, mon_b.c2);
                check("b_nrn_data0", bus_b.o_nrn_data0, mon_b.d0);
            end
        end
    end

    task automatic flush_a();
        clr_q.delete();
        en_q.delete();
        vld_q.delete();
        res_q.delete();
    endtask

    // offer a frame to A, record the accept cycle and queue the expected timeline
    task automatic send_a(input logic [7:0] d0, d1, d2, input logic [7:0] c0, c1, c2,
                          input bit keep, output int acc);
        int n;
        res_t r;
        @(posedge clk); #1;
        bus_a.i_in_valid = 1'b1;
        bus_a.i_in_data0 = d0;
        bus_a.i_in_data1 = d1;
        bus_a.i_in_data2 = d2;
        n = 0;
        @(negedge clk);
        while (!bus_a.o_in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        acc = cyc;
        if (!bus_a.o_in_ready) begin
            fail_now("accept_timeout");
        end else begin
            clr_q.push_back(acc + 1);
            for (int i = 0; i < T_A; i++) en_q.push_back(acc + 2 + i * (1 + S_A));
            vld_q.push_back(acc + 2 + T_A * (1 + S_A));
            r = '{c0: c0, c1: c1, c2: c2, d0: d0, d1: d1, d2: d2};
            res_q.push_back(r);
        end
        @(posedge clk); #1;
        if (!keep) bus_a.i_in_valid = 1'b0;
    endtask

    task automatic drain_a();
        int n;
        n = 0;
        while ((clr_q.size() + en_q.size() + vld_q.size() + res_q.size()) != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if ((clr_q.size() + en_q.size() + vld_q.size() + res_q.size()) != 0) begin
            fail_now("drain_timeout");
            flush_a();
        end
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_nrn_data0"}, bus_a.o_nrn_data0, 0);
        check({tag, "_nrn_data1"}, bus_a.o_nrn_data1, 0);
        check({tag, "_nrn_data2"}, bus_a.o_nrn_data2, 0);
        check({tag, "_cnt0"}, bus_a.o_cnt0, 0);
        check({tag, "_cnt1"}, bus_a.o_cnt1, 0);
        check({tag, "_cnt2"}, bus_a.o_cnt2, 0);
        check({tag, "_clr"}, bus_a.o_nrn_clr, 0);
        check({tag, "_en"}, bus_a.o_nrn_en, 0);
        check({tag, "_out_valid"}, bus_a.o_out_valid, 0);
        check({tag, "_in_ready"}, bus_a.o_in_ready, 1);
        check({tag, "_busy"}, bus_a.o_busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int acc, acc2, n;
        bus_a.i_in_valid = 1'b0;
        bus_a.i_in_data0 = '0;
        bus_a.i_in_data1 = '0;
        bus_a.i_in_data2 = '0;
        bus_a.i_out_ready = 1'b1;
        bus_b.i_in_valid = 1'b0;
        bus_b.i_in_data0 = '0;
        bus_b.i_in_data1 = '0;
        bus_b.i_in_data2 = '0;
        bus_b.i_out_ready = 1'b1;
        bus_b.i_spk0 = 1'b1;
        bus_b.i_spk1 = 1'b1;
        bus_b.i_spk2 = 1'b1;

        // power-on reset state
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_a("rst_init");
        check("rst_init_b_busy", bus_b.o_busy, 0);
        @(posedge clk); #1;
        rstn = 1'b1;

        // basic frame: spk0 every step, spk1 on steps 0 and 2, spk2 never
        pat0 = 16'hFFFF; pat1 = 16'h5555; pat2 = 16'h0000;
        send_a(8'd10, 8'd20, 8'd30, 8'd4, 8'd2, 8'd0, 1'b0, acc);
        drain_a();

        // backpressure in DONE with a competing frame offered
        bus_a.i_out_ready = 1'b0;
        send_a(8'd10, 8'd20, 8'd30, 8'd4, 8'd2, 8'd0, 1'b0, acc);
        n = 0;
        while (!bus_a.o_out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("stall_reached_done", bus_a.o_out_valid, 1);
        @(posedge clk); #1;
        bus_a.i_in_valid = 1'b1;
        bus_a.i_in_data0 = 8'd40;
        bus_a.i_in_data1 = 8'd40;
        bus_a.i_in_data2 = 8'd40;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", bus_a.o_out_valid, 1);
            check("stall_in_ready", bus_a.o_in_ready, 0);
            check("stall_cnt0", bus_a.o_cnt0, 4);
            check("stall_cnt1", bus_a.o_cnt1, 2);
            check("stall_cnt2", bus_a.o_cnt2, 0);
            check("stall_data0", bus_a.o_nrn_data0, 10);
        end
        @(posedge clk); #1;
        bus_a.i_out_ready = 1'b1;
        bus_a.i_in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("post_hs_in_ready", bus_a.o_in_ready, 1);
        check("post_hs_valid", bus_a.o_out_valid, 0);
        check("post_hs_busy", bus_a.o_busy, 0);
        check("post_hs_data0", bus_a.o_nrn_data0, 10);
        check("post_hs_data2", bus_a.o_nrn_data2, 30);
        drain_a();

        // reset held 3 cycles in the middle of a frame
        send_a(8'd50, 8'd60, 8'd70, 8'd0, 8'd0, 8'd0, 1'b0, acc);
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_a("rst_mid");
        flush_a();
        @(posedge clk); #1;
        rstn = 1'b1;

        // reset after the 2nd step enable, then a full fresh frame
        pat0 = 16'hFFFF; pat1 = 16'hFFFF; pat2 = 16'hFFFF;
        send_a(8'd9, 8'd9, 8'd9, 8'd0, 8'd0, 8'd0, 1'b0, acc);
        while (cyc < acc + 6) @(negedge clk);
        @(posedge clk); #1;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_a("rst_abort");
        flush_a();
        @(posedge clk); #1;
        rstn = 1'b1;
        send_a(8'd1, 8'd1, 8'd1, 8'd4, 8'd4, 8'd4, 1'b0, acc);
        drain_a();

        // back-to-back frames with valid and ready held high
        pat0 = 16'hFFFF; pat1 = 16'h0000; pat2 = 16'h0001;
        send_a(8'd0, 8'd0, 8'd0, 8'd4, 8'd0, 8'd1, 1'b1, acc);
        send_a(8'd40, 8'd40, 8'd40, 8'd4, 8'd0, 8'd1, 1'b0, acc2);
        check("b2b_after_handshake", acc2, last_hs + 1);
        check("b2b_accept_cycle", acc2, acc + 3 + T_A * (1 + S_A));
        drain_a();

        // saturation on instance B: 8 spikes into a 2-bit counter
        @(posedge clk); #1;
        bus_b.i_in_valid = 1'b1;
        bus_b.i_in_data0 = 8'd5;
        bus_b.i_in_data1 = 8'd6;
        bus_b.i_in_data2 = 8'd7;
        @(negedge clk);
        check("b_in_ready", bus_b.o_in_ready, 1);
        resb_q.push_back('{c0: 8'd3, c1: 8'd3, c2: 8'd3, d0: 8'd5, d1: 8'd6, d2: 8'd7});
        @(posedge clk); #1;
        bus_b.i_in_valid = 1'b0;
        n = 0;
        while (resb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (resb_q.size() != 0) fail_now("b_drain_timeout");

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
